instr_encoder: RTL and testbench

Sequential instruction encoder and program loader for the single-cycle core: the encoding end of the opcode/funct scheme the control unit decodes. It accepts one symbolic instruction per valid/ready handshake, range-checks its fields and packs it into a 16-bit instruction word. It writes that word into instruction memory at an auto-incrementing address, and releases the core with `cpu_run` once a HALT has been stored.

---
 rtl/instr_pkg.sv | 69 ++++++
 rtl/instr_encoder_if.sv | 13 +
 rtl/instr_pack.sv | 95 +++++++++
 rtl/instr_encoder.sv | 131 +++++++++++++
 tb/tb_instr_encoder.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_pkg.sv
// Shared definitions for the instruction encoder: mnemonics, opcode/funct
// constants, field positions, immediate limits, error codes and FSM states.
package instr_pkg;

  typedef enum logic [3:0] {
    MN_HALT = 4'd0,
    MN_LW   = 4'd1,
    MN_SW   = 4'd2,
    MN_JR   = 4'd3,
    MN_RST  = 4'd4,
    MN_INV  = 4'd5,
    MN_BEQZ = 4'd6,
    MN_ADD  = 4'd7,
    MN_ADDI = 4'd8,
    MN_J    = 4'd9,
    MN_BEQR = 4'd10,
    MN_SLT  = 4'd11
  } mnem_e;

  // Major opcodes in [15:14].
  localparam logic [1:0] OP_SYS = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_IMM = 2'b10;
  localparam logic [1:0] OP_REG = 2'b11;

  // Funct values for the system/memory group.
  localparam logic [2:0] FN_HALT = 3'b000;
  localparam logic [2:0] FN_LW   = 3'b001;
  localparam logic [2:0] FN_SW   = 3'b010;
  localparam logic [2:0] FN_JR   = 3'b011;
  localparam logic [2:0] FN_RST  = 3'b100;
  localparam logic [2:0] FN_INV  = 3'b101;
  localparam logic [2:0] FN_BEQZ = 3'b110;

  // Field LSB positions. F1 is the funct slot (also rd for ADD), F2/F3 the
  // register slots, SEL_BIT distinguishes the two forms inside OP_IMM/OP_REG.
  localparam int OP_LSB  = 14;
  localparam int F1_LSB  = 11;
  localparam int F2_LSB  = 8;
  localparam int F3_LSB  = 5;
  localparam int SEL_BIT = 11;

  // Signed immediate limits for the 5-bit and 8-bit immediate forms.
  localparam int IMM5_MIN = -16;
  localparam int IMM5_MAX = 15;
  localparam int IMM8_MIN = -128;
  localparam int IMM8_MAX = 127;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_RANGE   = 2'b10;
  localparam logic [1:0] ERR_FULL    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WRITE,
    S_ERROR,
    S_DONE
  } state_e;

  // True when the 11-bit two's-complement immediate lies within [lo, hi].
  function automatic logic in_range(input logic [10:0] imm, input int lo, input int hi);
    int v;
    v = int'($signed(imm));
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Command channel into the encoder: one symbolic instruction per valid/ready.
interface instr_encoder_if;
  logic        valid;
  logic        ready;
  logic [3:0]  mnem;
  logic [2:0]  ra;
  logic [2:0]  rb;
  logic [2:0]  rc;
  logic [10:0] imm;

  modport master (output valid, mnem, ra, rb, rc, imm, input ready);
  modport slave  (input valid, mnem, ra, rb, rc, imm, output ready);
endinterface

// File: rtl/instr_pack.sv
// Combinational packer: turns a mnemonic and its fields into a 16-bit word
// and flags illegal mnemonics and out-of-range immediates.
module instr_pack
  import instr_pkg::*;
(
  input  logic [3:0]  mnem,
  input  logic [2:0]  ra,
  input  logic [2:0]  rb,
  input  logic [2:0]  rc,
  input  logic [10:0] imm,
  output logic [15:0] word,
  output logic        illegal,
  output logic        range_err
);

  // Lay out opcode, funct and operand fields per mnemonic; unused bits stay zero.
  // NOTE: every output is given a default first so no path can infer a latch.
  always_comb begin
    word      = '0;
    illegal   = 1'b0;
    range_err = 1'b0;
    case (mnem)
      MN_HALT: begin
        word[OP_LSB +: 2] = OP_SYS;
        word[F1_LSB +: 3] = FN_HALT;
      end
      MN_LW, MN_SW: begin
        word[OP_LSB +: 2] = OP_SYS;
        word[F1_LSB +: 3] = (mnem == MN_LW) ? FN_LW : FN_SW;
        word[F2_LSB +: 3] = ra;
        word[F3_LSB +: 3] = rb;
        word[4:0]         = imm[4:0];
        range_err         = !in_range(imm, IMM5_MIN, IMM5_MAX);
      end
      MN_JR: begin
        word[OP_LSB +: 2] = OP_SYS;
        word[F1_LSB +: 3] = FN_JR;
        word[F2_LSB +: 3] = ra;
      end
      MN_RST: begin
        word[OP_LSB +: 2] = OP_SYS;
        word[F1_LSB +: 3] = FN_RST;
        word[F2_LSB +: 3] = ra;
      end
      MN_INV: begin
        word[OP_LSB +: 2] = OP_SYS;
        word[F1_LSB +: 3] = FN_INV;
        word[F2_LSB +: 3] = ra;
      end
      MN_BEQZ: begin
        word[OP_LSB +: 2] = OP_SYS;
        word[F1_LSB +: 3] = FN_BEQZ;
        word[F2_LSB +: 3] = ra;
        word[7:0]         = imm[7:0];
        range_err         = !in_range(imm, IMM8_MIN, IMM8_MAX);
      end
      MN_ADD: begin
        word[OP_LSB +: 2] = OP_ADD;
        word[F1_LSB +: 3] = ra;
        word[F2_LSB +: 3] = rb;
        word[F3_LSB +: 3] = rc;
      end
      MN_ADDI: begin
        word[OP_LSB +: 2] = OP_IMM;
        word[SEL_BIT]     = 1'b0;
        word[F2_LSB +: 3] = ra;
        word[7:0]         = imm[7:0];
        range_err         = !in_range(imm, IMM8_MIN, IMM8_MAX);
      end
      MN_J: begin
        // Jump target is unsigned and uses the full 11 bits, so it cannot overflow.
        word[OP_LSB +: 2] = OP_IMM;
        word[SEL_BIT]     = 1'b1;
        word[10:0]        = imm;
      end
      MN_BEQR: begin
        word[OP_LSB +: 2] = OP_REG;
        word[SEL_BIT]     = 1'b0;
        word[F2_LSB +: 3] = ra;
        word[F3_LSB +: 3] = rb;
        word[4:0]         = imm[4:0];
        range_err         = !in_range(imm, IMM5_MIN, IMM5_MAX);
      end
      MN_SLT: begin
        word[OP_LSB +: 2] = OP_REG;
        word[SEL_BIT]     = 1'b1;
        word[F2_LSB +: 3] = ra;
        word[F3_LSB +: 3] = rb;
        word[4:0]         = {2'b00, rc};
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Sequential instruction encoder / program loader. Accepts commands, checks
// and packs them, writes them to instruction memory at an auto-incrementing
// address and raises cpu_run once a HALT has been stored.
module instr_encoder
  import instr_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  instr_encoder_if.slave    cmd,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              err,
  output logic [1:0]        err_code,
  output logic              prog_done,
  output logic              cpu_run
);

  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_e      state;
  logic        we_q;
  logic [3:0]  mnem_q;
  logic [2:0]  ra_q;
  logic [2:0]  rb_q;
  logic [2:0]  rc_q;
  logic [10:0] imm_q;
  logic [15:0] packed_word;
  logic        illegal;
  logic        range_err;

  // A load_start in the same cycle wins over a new command and over a pending write.
  assign cmd.ready = rst_n && (state == S_IDLE) && !load_start;
  assign imem_we   = we_q && !load_start;

  instr_pack u_pack (
    .mnem      (mnem_q),
    .ra        (ra_q),
    .rb        (rb_q),
    .rc        (rc_q),
    .imm       (imm_q),
    .word      (packed_word),
    .illegal   (illegal),
    .range_err (range_err)
  );

  // Capture the command fields on the handshake for CHECK and WRITE.
  // NOTE: these are pure data registers without reset; they are always loaded before use.
  always_ff @(posedge clk) begin
    if (cmd.valid && cmd.ready) begin
      mnem_q <= cmd.mnem;
      ra_q   <= cmd.ra;
      rb_q   <= cmd.rb;
      rc_q   <= cmd.rc;
      imm_q  <= cmd.imm;
    end
  end

  // Load FSM with registered memory strobe, address/word counters and status.
  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      we_q       <= 1'b0;
      imem_addr  <= BASE;
      imem_wdata <= '0;
      word_count <= '0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
      prog_done  <= 1'b0;
      cpu_run    <= 1'b0;
    end else if (load_start) begin
      state      <= S_IDLE;
      we_q       <= 1'b0;
      imem_addr  <= BASE;
      word_count <= '0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
      prog_done  <= 1'b0;
      cpu_run    <= 1'b0;
    end else begin
      prog_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd.valid && cmd.ready) state <= S_CHECK;
        end
        S_CHECK: begin
          if (illegal) begin
            state    <= S_ERROR;
            err      <= 1'b1;
            err_code <= ERR_ILLEGAL;
          end else if (range_err) begin
            state    <= S_ERROR;
            err      <= 1'b1;
            err_code <= ERR_RANGE;
          end else if (word_count == DEPTH) begin
            state    <= S_ERROR;
            err      <= 1'b1;
            err_code <= ERR_FULL;
          end else begin
            state      <= S_WRITE;
            we_q       <= 1'b1;
            imem_wdata <= packed_word;
          end
        end
        S_WRITE: begin
          // Address wraps naturally; word_count keeps the extra bit to detect full.
          we_q       <= 1'b0;
          imem_addr  <= imem_addr + 1'b1;
          word_count <= word_count + 1'b1;
          if (mnem_q == MN_HALT) begin
            state     <= S_DONE;
            prog_done <= 1'b1;
            cpu_run   <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ERROR, S_DONE: state <= state;
        default:         state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: an 8-bit-address instance for encoding,
// errors and load/reset behaviour, and a 2-bit-address instance for wrap/full.
module tb_instr_encoder;
  import instr_pkg::*;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] word;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_a = 1'b0;
  logic load_b = 1'b0;

  always #5 clk = ~clk;

  instr_encoder_if a_if ();
  instr_encoder_if b_if ();

  logic        we_a, err_a, done_a, run_a;
  logic [7:0]  addr_a;
  logic [15:0] wdata_a;
  logic [8:0]  cnt_a;
  logic [1:0]  code_a;

  logic        we_b, err_b, done_b, run_b;
  logic [1:0]  addr_b;
  logic [15:0] wdata_b;
  logic [2:0]  cnt_b;
  logic [1:0]  code_b;

  instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_a),
    .cmd        (a_if.slave),
    .imem_we    (we_a),
    .imem_addr  (addr_a),
    .imem_wdata (wdata_a),
    .word_count (cnt_a),
    .err        (err_a),
    .err_code   (code_a),
    .prog_done  (done_a),
    .cpu_run    (run_a)
  );

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_b),
    .cmd        (b_if.slave),
    .imem_we    (we_b),
    .imem_addr  (addr_b),
    .imem_wdata (wdata_b),
    .word_count (cnt_b),
    .err        (err_b),
    .err_code   (code_b),
    .prog_done  (done_b),
    .cpu_run    (run_b)
  );

  int  vectors = 0;
  int  miscompares = 0;
  wr_t q_a[$];
  wr_t q_b[$];
  wr_t e_a;
  wr_t e_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard for instance A: every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (we_a === 1'b1) begin
      if (q_a.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL a_unexpected_write: observed write addr %0h data %0h, expected none", addr_a, wdata_a);
      end else begin
        e_a = q_a.pop_front();
        check("a_wr_addr", addr_a, e_a.addr);
        check("a_wr_data", wdata_a, e_a.word);
        check("a_wr_done_overlap", done_a, 0);
      end
    end
  end

  // Scoreboard for instance B.
  always @(negedge clk) begin
    if (we_b === 1'b1) begin
      if (q_b.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL b_unexpected_write: observed write addr %0h data %0h, expected none", addr_b, wdata_b);
      end else begin
        e_b = q_b.pop_front();
        check("b_wr_addr", addr_b, e_b.addr);
        check("b_wr_data", wdata_b, e_b.word);
        check("b_wr_done_overlap", done_b, 0);
      end
    end
  end

  function automatic logic rdy(input bit sel);
    return sel ? b_if.ready : a_if.ready;
  endfunction

  task automatic drive(input bit sel, input logic v, input logic [3:0] mn,
                       input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] rc,
                       input logic [10:0] imm);
    if (sel) begin
      b_if.valid = v; b_if.mnem = mn; b_if.ra = ra; b_if.rb = rb; b_if.rc = rc; b_if.imm = imm;
    end else begin
      a_if.valid = v; a_if.mnem = mn; a_if.ra = ra; a_if.rb = rb; a_if.rc = rc; a_if.imm = imm;
    end
  endtask

  // Called at a negedge; returns at the negedge of the cycle where the write (if any) is visible.
  task automatic send(input bit sel, input logic [3:0] mn, input logic [2:0] ra,
                      input logic [2:0] rb, input logic [2:0] rc, input logic [10:0] imm,
                      input logic exp_write, input string tag);
    bit hs = 1'b0;
    drive(sel, 1'b1, mn, ra, rb, rc, imm);
    for (int i = 0; i < 20 && !hs; i++) begin
      if (rdy(sel)) hs = 1'b1;
      else @(negedge clk);
    end
    if (!hs) begin
      vectors++;
      miscompares++;
      $error("FAIL %s_handshake: observed no cmd_ready within 20 cycles, expected handshake", tag);
      drive(sel, 1'b0, mn, ra, rb, rc, imm);
    end else begin
      @(posedge clk);
      @(negedge clk);
      drive(sel, 1'b0, mn, ra, rb, rc, imm);
      check({tag, "_we_check_cycle"}, sel ? we_b : we_a, 0);
      check({tag, "_ready_check_cycle"}, rdy(sel), 0);
      @(negedge clk);
      check({tag, "_we_write_cycle"}, sel ? we_b : we_a, exp_write);
    end
  endtask

  task automatic pulse_load(input bit sel);
    @(negedge clk);
    if (sel) load_b = 1'b1; else load_a = 1'b1;
    @(negedge clk);
    if (sel) load_b = 1'b0; else load_a = 1'b0;
    #1;
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_we"},    we_a,    0);
    check({tag, "_addr"},  addr_a,  0);
    check({tag, "_wdata"}, wdata_a, 0);
    check({tag, "_count"}, cnt_a,   0);
    check({tag, "_err"},   err_a,   0);
    check({tag, "_code"},  code_a,  0);
    check({tag, "_done"},  done_a,  0);
    check({tag, "_run"},   run_a,   0);
    check({tag, "_ready"}, a_if.ready, 0);
  endtask

  // Safety net so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(1'b0, 1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 11'd0);
    drive(1'b1, 1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 11'd0);

    // Reset values.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_a("rst");
    check("rst_b_ready", b_if.ready, 0);
    rst_n = 1'b1;
    #1;
    check("rst_release_ready", a_if.ready, 1);
    @(negedge clk);

    // ADD ra=3 rb=1 rc=2 at address 0, write exactly two cycles after handshake.
    q_a.push_back('{8'd0, 16'h5940});
    send(1'b0, MN_ADD, 3'd3, 3'd1, 3'd2, 11'd0, 1'b1, "add");
    check("add_wdata_stable", wdata_a, 16'h5940);
    @(negedge clk);
    check("add_ready_again", a_if.ready, 1);
    check("add_addr_inc", addr_a, 1);
    check("add_count", cnt_a, 1);

    // Program ADDI/J/LW/HALT.
    pulse_load(1'b0);
    check("prog_count_cleared", cnt_a, 0);
    q_a.push_back('{8'd0, 16'h82FF});
    q_a.push_back('{8'd1, 16'h8805});
    q_a.push_back('{8'd2, 16'h099E});
    q_a.push_back('{8'd3, 16'h0000});
    send(1'b0, MN_ADDI, 3'd2, 3'd0, 3'd0, 11'h7FF, 1'b1, "prog_addi");
    send(1'b0, MN_J,    3'd0, 3'd0, 3'd0, 11'd5,   1'b1, "prog_j");
    send(1'b0, MN_LW,   3'd1, 3'd4, 3'd0, 11'h7FE, 1'b1, "prog_lw");
    send(1'b0, MN_HALT, 3'd0, 3'd0, 3'd0, 11'd0,   1'b1, "prog_halt");
    @(negedge clk);
    check("prog_done_pulse", done_a, 1);
    check("prog_run", run_a, 1);
    check("prog_count", cnt_a, 4);
    check("prog_ready_low", a_if.ready, 0);
    @(negedge clk);
    check("prog_done_cleared", done_a, 0);
    check("prog_run_held", run_a, 1);
    repeat (3) @(negedge clk);
    check("prog_done_once", done_a, 0);

    // Range error, hold, recovery via load_start.
    pulse_load(1'b0);
    check("ld_err_clear", err_a, 0);
    check("ld_run_clear", run_a, 0);
    q_a.push_back('{8'd0, 16'h5940});
    send(1'b0, MN_ADD, 3'd3, 3'd1, 3'd2, 11'd0, 1'b1, "pre_err_add");
    send(1'b0, MN_ADDI, 3'd0, 3'd0, 3'd0, 11'd200, 1'b0, "addi_range");
    check("range_err", err_a, 1);
    check("range_code", code_a, 2'b10);
    drive(1'b0, 1'b1, MN_ADD, 3'd1, 3'd1, 3'd1, 11'd0);
    repeat (4) @(negedge clk);
    check("range_ready_held", a_if.ready, 0);
    check("range_count_held", cnt_a, 1);
    drive(1'b0, 1'b0, MN_ADD, 3'd1, 3'd1, 3'd1, 11'd0);
    pulse_load(1'b0);
    check("recover_err", err_a, 0);
    check("recover_code", code_a, 0);
    check("recover_ready", a_if.ready, 1);
    q_a.push_back('{8'd0, 16'h5A60});
    send(1'b0, MN_ADD, 3'd3, 3'd2, 3'd3, 11'd0, 1'b1, "recover_add");
    @(negedge clk);
    check("recover_count", cnt_a, 1);

    // load_start together with cmd_valid: command not accepted.
    drive(1'b0, 1'b1, MN_ADD, 3'd1, 3'd1, 3'd1, 11'd0);
    load_a = 1'b1;
    #1;
    check("ld_valid_ready", a_if.ready, 0);
    @(negedge clk);
    load_a = 1'b0;
    drive(1'b0, 1'b0, MN_ADD, 3'd1, 3'd1, 3'd1, 11'd0);
    #1;
    check("ld_valid_not_taken", a_if.ready, 1);
    check("ld_valid_count", cnt_a, 0);
    repeat (3) @(negedge clk);
    check("ld_valid_addr", addr_a, 0);

    // Illegal mnemonic.
    send(1'b0, 4'd13, 3'd0, 3'd0, 3'd0, 11'd0, 1'b0, "illegal");
    check("illegal_err", err_a, 1);
    check("illegal_code", code_a, 2'b01);

    // Remaining encodings and immediate boundaries.
    pulse_load(1'b0);
    q_a.push_back('{8'd0, 16'h3580});
    q_a.push_back('{8'd1, 16'hC76F});
    q_a.push_back('{8'd2, 16'hC946});
    q_a.push_back('{8'd3, 16'h10EF});
    q_a.push_back('{8'd4, 16'h1C00});
    q_a.push_back('{8'd5, 16'h2200});
    q_a.push_back('{8'd6, 16'h2900});
    q_a.push_back('{8'd7, 16'h8FFF});
    q_a.push_back('{8'd8, 16'h867F});
    q_a.push_back('{8'd9, 16'h0810});
    send(1'b0, MN_BEQZ, 3'd5, 3'd0, 3'd0, 11'h780, 1'b1, "beqz_min");
    send(1'b0, MN_BEQR, 3'd7, 3'd3, 3'd0, 11'd15,  1'b1, "beqr_max");
    send(1'b0, MN_SLT,  3'd1, 3'd2, 3'd6, 11'd0,   1'b1, "slt");
    send(1'b0, MN_SW,   3'd0, 3'd7, 3'd0, 11'd15,  1'b1, "sw");
    send(1'b0, MN_JR,   3'd4, 3'd7, 3'd7, 11'd5,   1'b1, "jr");
    send(1'b0, MN_RST,  3'd2, 3'd0, 3'd0, 11'd0,   1'b1, "rst");
    send(1'b0, MN_INV,  3'd1, 3'd0, 3'd0, 11'd0,   1'b1, "inv");
    send(1'b0, MN_J,    3'd0, 3'd0, 3'd0, 11'h7FF, 1'b1, "j_max");
    send(1'b0, MN_ADDI, 3'd6, 3'd0, 3'd0, 11'd127, 1'b1, "addi_max");
    send(1'b0, MN_LW,   3'd0, 3'd0, 3'd0, 11'h7F0, 1'b1, "lw_min");
    @(negedge clk);
    check("batch_count", cnt_a, 10);
    check("batch_addr", addr_a, 10);
    send(1'b0, MN_BEQZ, 3'd1, 3'd0, 3'd0, 11'h77F, 1'b0, "beqz_under");
    check("beqz_under_code", code_a, 2'b10);
    pulse_load(1'b0);
    send(1'b0, MN_BEQR, 3'd1, 3'd2, 3'd0, 11'd16, 1'b0, "beqr_over");
    check("beqr_over_code", code_a, 2'b10);

    // load_start during the WRITE cycle aborts the write.
    pulse_load(1'b0);
    q_a.push_back('{8'd0, 16'h5940});
    send(1'b0, MN_ADD, 3'd3, 3'd1, 3'd2, 11'd0, 1'b1, "pre_abort");
    @(negedge clk);
    drive(1'b0, 1'b1, MN_ADD, 3'd1, 3'd2, 3'd3, 11'd0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, MN_ADD, 3'd1, 3'd2, 3'd3, 11'd0);
    check("abort_in_check", a_if.ready, 0);
    @(posedge clk);
    #1;
    load_a = 1'b1;
    #1;
    check("abort_we_forced", we_a, 0);
    @(posedge clk);
    @(negedge clk);
    load_a = 1'b0;
    #1;
    check("abort_addr", addr_a, 0);
    check("abort_count", cnt_a, 0);
    check("abort_ready", a_if.ready, 1);

    // Synchronous reset while in CHECK.
    q_a.push_back('{8'd0, 16'h8805});
    send(1'b0, MN_J, 3'd0, 3'd0, 3'd0, 11'd5, 1'b1, "pre_reset");
    @(negedge clk);
    drive(1'b0, 1'b1, MN_ADDI, 3'd1, 3'd0, 3'd0, 11'd3);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, MN_ADDI, 3'd1, 3'd0, 3'd0, 11'd3);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_a("mid_rst");
    rst_n = 1'b1;
    #1;
    check("mid_rst_ready", a_if.ready, 1);
    repeat (3) @(negedge clk);
    check("mid_rst_no_write_count", cnt_a, 0);

    // Instance B: 4-deep memory, wrap and full.
    q_b.push_back('{8'd0, 16'h4A60});
    q_b.push_back('{8'd1, 16'h5380});
    q_b.push_back('{8'd2, 16'h65C0});
    q_b.push_back('{8'd3, 16'h7FE0});
    send(1'b1, MN_ADD, 3'd1, 3'd2, 3'd3, 11'd0, 1'b1, "b_add0");
    send(1'b1, MN_ADD, 3'd2, 3'd3, 3'd4, 11'd0, 1'b1, "b_add1");
    send(1'b1, MN_ADD, 3'd4, 3'd5, 3'd6, 11'd0, 1'b1, "b_add2");
    send(1'b1, MN_ADD, 3'd7, 3'd7, 3'd7, 11'd0, 1'b1, "b_add3");
    @(negedge clk);
    check("b_wrap_addr", addr_b, 0);
    check("b_full_count", cnt_b, 4);
    send(1'b1, MN_ADD, 3'd1, 3'd1, 3'd1, 11'd0, 1'b0, "b_overflow");
    check("b_full_err", err_b, 1);
    check("b_full_code", code_b, 2'b11);
    pulse_load(1'b1);
    q_b.push_back('{8'd0, 16'h4A60});
    q_b.push_back('{8'd1, 16'h4A60});
    q_b.push_back('{8'd2, 16'h4A60});
    q_b.push_back('{8'd3, 16'h0000});
    send(1'b1, MN_ADD,  3'd1, 3'd2, 3'd3, 11'd0, 1'b1, "b_fill0");
    send(1'b1, MN_ADD,  3'd1, 3'd2, 3'd3, 11'd0, 1'b1, "b_fill1");
    send(1'b1, MN_ADD,  3'd1, 3'd2, 3'd3, 11'd0, 1'b1, "b_fill2");
    send(1'b1, MN_HALT, 3'd0, 3'd0, 3'd0, 11'd0, 1'b1, "b_halt_last");
    @(negedge clk);
    check("b_halt_done", done_b, 1);
    check("b_halt_run", run_b, 1);
    check("b_halt_err", err_b, 0);
    check("b_halt_count", cnt_b, 4);

    repeat (2) @(negedge clk);
    check("a_queue_drained", q_a.size(), 0);
    check("b_queue_drained", q_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
